alu_pipe_responder: RTL and testbench

//  - Clocked, handshaked ALU responder: accepts {Select,A,B} operation requests, returns {Result,N,V,Z,C}.
//  - Sits behind the vector-driven ALU bench and bus masters as the DUT-side endpoint.
//  - 2-stage pipeline: S1 operand register, S2 compute + result register.
//  - valid/ready on both sides; backpressure propagates to the requester.

---
 rtl/alu_pipe_pkg.sv | 25 ++
 rtl/alu_pipe_core.sv | 67 ++++++
 rtl/alu_pipe_responder.sv | 135 +++++++++++++
 tb/tb_alu_pipe_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Package for the handshaked ALU responder.
// Holds opcode encodings, flag bit positions inside the packed flag vector,
// and the default operand width shared by the top and the compute core.
package alu_pipe_pkg;

  localparam int DEF_WIDTH = 8;

  // Opcode encodings carried on Select
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  // Bit positions of the flags inside a packed {N,V,Z,C} vector
  localparam int FLG_W = 4;
  localparam int FLG_N = 3;
  localparam int FLG_V = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_C = 0;

endpackage

// File: rtl/alu_pipe_core.sv
// Purely combinational ALU used as the S2 compute stage.
// Ports:
//   sel    : opcode (see alu_pipe_pkg OP_*)
//   a, b   : operands
//   result : low WIDTH bits of the WIDTH+1 bit internal result
//   flags  : packed {N,V,Z,C}, bit positions from alu_pipe_pkg FLG_*
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [FLG_W-1:0] flags
);

  logic [WIDTH:0] wide_s;
  logic           v_s;
  logic           c_s;

  // Opcode decode, result and flag generation
  always_comb begin
    wide_s = {(WIDTH+1){1'b0}};
    v_s    = 1'b0;
    c_s    = 1'b0;
    case (sel)
      OP_ADD: begin
        wide_s = {1'b0, a} + {1'b0, b};
        c_s    = wide_s[WIDTH];
        // overflow: operands agree in sign, result does not
        v_s    = (a[WIDTH-1] == b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide_s = {1'b0, a} - {1'b0, b};
        // the extra bit goes high exactly when a < b (borrow)
        c_s    = wide_s[WIDTH];
        v_s    = (a[WIDTH-1] != b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: wide_s = {1'b0, a & b};
      OP_OR:  wide_s = {1'b0, a | b};
      OP_XOR: wide_s = {1'b0, a ^ b};
      OP_NOT: wide_s = {1'b0, ~a};
      OP_SHL: begin
        wide_s = {1'b0, a[WIDTH-2:0], 1'b0};
        c_s    = a[WIDTH-1];
      end
      OP_SHR: begin
        wide_s = {2'b00, a[WIDTH-1:1]};
        c_s    = a[0];
      end
      default: begin
        wide_s = {(WIDTH+1){1'b0}};
        v_s    = 1'b0;
        c_s    = 1'b0;
      end
    endcase
    result        = wide_s[WIDTH-1:0];
    flags         = {FLG_W{1'b0}};
    flags[FLG_N]  = wide_s[WIDTH-1];
    flags[FLG_V]  = v_s;
    flags[FLG_Z]  = (wide_s[WIDTH-1:0] == {WIDTH{1'b0}});
    flags[FLG_C]  = c_s;
  end

endmodule

// File: rtl/alu_pipe_responder.sv
// Two-stage handshaked ALU responder.
//   S1 registers the accepted request, S2 registers the computed response.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : request handshake; Select, A, B carry the request
//   use_acc              : (ALU_PIPE_ACCUM_EN only) take operand A from the accumulator
//   out_valid / out_ready: response handshake; Result, N, V, Z, C carry the response
// Build option: define ALU_PIPE_ACCUM_EN to add the accumulator and use_acc port.
module alu_pipe_responder
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Select,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ALU_PIPE_ACCUM_EN
  input  logic             use_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             N,
  output logic             V,
  output logic             Z,
  output logic             C
);

  logic             s1_valid_r;
  logic [2:0]       s1_sel_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [FLG_W-1:0] flags_r;

  logic             s1_adv_s;
  logic             s2_adv_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] core_a_s;
  logic [WIDTH-1:0] core_res_s;
  logic [FLG_W-1:0] core_flags_s;

`ifdef ALU_PIPE_ACCUM_EN
  logic             s1_acc_r;
  logic [WIDTH-1:0] acc_r;
  logic             hazard_s;
`endif

  // Pipeline advance and request-side ready
  always_comb begin
    s2_adv_s = !s2_valid_r || out_ready;
    s1_adv_s = !s1_valid_r || s2_adv_s;
`ifdef ALU_PIPE_ACCUM_EN
    // A use_acc request waits until every older op has been handed off;
    // accepting during the handoff cycle is fine since acc_r updates on that edge.
    hazard_s   = use_acc && (s1_valid_r || (s2_valid_r && !out_ready));
    in_ready_s = s1_adv_s && !hazard_s;
    core_a_s   = s1_acc_r ? acc_r : s1_a_r;
`else
    in_ready_s = s1_adv_s;
    core_a_s   = s1_a_r;
`endif
    accept_s = in_valid && in_ready_s;
  end

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .sel    (s1_sel_r),
    .a      (core_a_s),
    .b      (s1_b_r),
    .result (core_res_s),
    .flags  (core_flags_s)
  );

  // S1 operand register and S2 result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sel_r   <= 3'd0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s2_valid_r <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      flags_r    <= {FLG_W{1'b0}};
    end else begin
      if (s1_adv_s) begin
        s1_valid_r <= accept_s;
      end
      if (accept_s) begin
        s1_sel_r <= Select;
        s1_a_r   <= A;
        s1_b_r   <= B;
      end
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
      end
      // result/flags only change when a new op moves in, so they hold while stalled
      if (s2_adv_s && s1_valid_r) begin
        result_r <= core_res_s;
        flags_r  <= core_flags_s;
      end
    end
  end

`ifdef ALU_PIPE_ACCUM_EN
  // Accumulator tracks the last response handed off, plus the per-op use_acc tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r    <= {WIDTH{1'b0}};
      s1_acc_r <= 1'b0;
    end else begin
      if (s2_valid_r && out_ready) begin
        acc_r <= result_r;
      end
      if (accept_s) begin
        s1_acc_r <= use_acc;
      end
    end
  end
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = s2_valid_r;
  assign Result    = result_r;
  assign N         = flags_r[FLG_N];
  assign V         = flags_r[FLG_V];
  assign Z         = flags_r[FLG_Z];
  assign C         = flags_r[FLG_C];

endmodule

// File: tb/tb_alu_pipe_responder.sv
// Self-checking bench for alu_pipe_responder (WIDTH=8).
// Expected responses are queued on acceptance and compared on handoff.
module tb_alu_pipe_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] Select;
  logic [7:0] A;
  logic [7:0] B;
`ifdef ALU_PIPE_ACCUM_EN
  logic       use_acc;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Result;
  logic       N, V, Z, C;

  int total = 0;
  int bad   = 0;
  int nresp = 0;
  logic [11:0] sbq[$];

  always #5 clk = ~clk;

  alu_pipe_responder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Select    (Select),
    .A         (A),
    .B         (B),
`ifdef ALU_PIPE_ACCUM_EN
    .use_acc   (use_acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .N         (N),
    .V         (V),
    .Z         (Z),
    .C         (C)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Independent reference: integer arithmetic, returns {result, N, V, Z, C}
  function automatic logic [11:0] model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, t;
    logic [7:0] r;
    logic v, c;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    v = 1'b0; c = 1'b0; r = 8'h00; t = 0;
    case (s)
      3'd0: begin t = ua + ub; r = t[7:0]; c = (t > 255); t = sa + sb; v = (t > 127) || (t < -128); end
      3'd1: begin r = a - b; c = (ua < ub); t = sa - sb; v = (t > 127) || (t < -128); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: begin r = {1'b0, a[7:1]}; c = a[0]; end
    endcase
    return {r, r[7], v, (r == 8'h00), c};
  endfunction

  // Response monitor: pop and compare on every handoff
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      nresp++;
      chk("resp_queue_nonempty", (sbq.size() != 0), 1);
      if (sbq.size() != 0) chk("resp", {Result, N, V, Z, C}, sbq.pop_front());
    end
  end

  // Drive one request until accepted (bounded), queueing its expected response
  task automatic send(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                      input logic [11:0] exp);
    int n;
    logic ok;
    n = 0; ok = 1'b0;
    in_valid = 1'b1; Select = s; A = a; B = b;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; sbq.push_back(exp); end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("accept", ok, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    int acc_cnt, cyc, idx;
    logic [2:0] bp_op[5];
    logic [7:0] bp_a[5];
    logic [7:0] bp_b[5];
    rst_n = 1'b0; in_valid = 1'b0; Select = 3'd0; A = 8'h00; B = 8'h00; out_ready = 1'b1;
`ifdef ALU_PIPE_ACCUM_EN
    use_acc = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {Result, N, V, Z, C}, 12'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors with hand-derived results {Result, N,V,Z,C}
    send(3'd0, 8'h7F, 8'h01, {8'h80, 4'b1100});
    send(3'd0, 8'hFF, 8'h01, {8'h00, 4'b0011});
    send(3'd1, 8'h00, 8'h01, {8'hFF, 4'b1001});
    send(3'd1, 8'h80, 8'h01, {8'h7F, 4'b0100});
    send(3'd6, 8'h81, 8'h00, {8'h02, 4'b0001});
    send(3'd7, 8'h01, 8'h00, {8'h00, 4'b0011});
    send(3'd5, 8'hFF, 8'h00, {8'h00, 4'b0010});
    drain();

    // Throughput: back-to-back ops, in_ready must stay high
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; Select = i[2:0]; A = 8'($urandom_range(0, 255)); B = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk("tput_ready", in_ready, 1);
      if (in_ready) sbq.push_back(model(Select, A, B));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: 5 ops, out_ready low for 4 cycles
    bp_op = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd1};
    bp_a  = '{8'h12, 8'hF0, 8'h0F, 8'hAA, 8'h05};
    bp_b  = '{8'h34, 8'h3C, 8'h30, 8'hFF, 8'h09};
    out_ready = 1'b0; idx = 0; cyc = 0; acc_cnt = 0;
    nresp = 0;
    while (idx < 5 && cyc < 40) begin
      in_valid = 1'b1; Select = bp_op[idx]; A = bp_a[idx]; B = bp_b[idx];
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        chk("bp_ready_low", in_ready, 0);
        chk("bp_accepts", acc_cnt, 2);
        chk("bp_hold", {out_valid, Result, N, V, Z, C}, {1'b1, model(bp_op[0], bp_a[0], bp_b[0])});
      end
      if (in_ready) begin
        sbq.push_back(model(Select, A, B));
        acc_cnt++;
      end
      @(posedge clk); #1;
      if (in_ready || sbq.size() > acc_cnt) idx = acc_cnt;
      idx = acc_cnt;
      cyc++;
      if (cyc == 4) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    drain();
    chk("bp_resp_count", nresp, 5);

    // Mid-stream reset: two ops in flight are discarded
    out_ready = 1'b0;
    send(3'd0, 8'h01, 8'h02, 12'h000);
    send(3'd0, 8'h03, 8'h04, 12'h000);
    rst_n = 1'b0;
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", {Result, N, V, Z, C}, 12'h000);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    // Latency: out_valid low after the accept edge, high after the next edge
    in_valid = 1'b1; Select = 3'd4; A = 8'h5A; B = 8'h0F;
    @(negedge clk);
    chk("lat_ready", in_ready, 1);
    if (in_ready) sbq.push_back({8'h55, 4'b0000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1", out_valid, 0);
    @(negedge clk);
    chk("lat_edge2", out_valid, 1);
    drain();

`ifdef ALU_PIPE_ACCUM_EN
    // Accumulator: 5+3 then acc+2, second request held off until the first hands off
    send(3'd0, 8'h05, 8'h03, {8'h08, 4'b0000});
    use_acc = 1'b1; in_valid = 1'b1; Select = 3'd0; A = 8'hAA; B = 8'h02;
    @(negedge clk);
    chk("acc_stall", in_ready, 0);
    @(posedge clk); #1;
    use_acc = 1'b0;
    send(3'd0, 8'hAA, 8'h02, 12'h000);
    void'(sbq.pop_back());
    use_acc = 1'b1;
    send(3'd0, 8'hAA, 8'h02, {8'h0A, 4'b0000});
    use_acc = 1'b0;
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
